// File: rtl/reset_pkg.sv
// Purpose : shared types and constants for the reset sequencer slice.
// Latency : n/a (declarations only).
// Backpr. : n/a (declarations only).
package reset_pkg;

    // Upper bound on the number of sequenced reset outputs.
    localparam int unsigned MAX_STAGES = 8;

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        DONE      = 3'd3,
        SOFT_HOLD = 3'd4
    } reset_state_t;

    // Largest of three sizing parameters, used to size the shared state counter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_filter.sv
// Purpose : synchronizes the PLL lock flag and qualifies it after LOCK_FILTER
//           consecutive high samples (saturating debounce counter).
// Latency : lock rising before edge E -> lock_qualified high after edge E+1+LOCK_FILTER.
// Backpr. : none; free-running filter, a single low sample disqualifies at once.
// Ports   : clock_in, async_reset_n_in (async active-low), pll_locked_in (async),
//           lock_qualified (registered).
module lock_filter #(
    parameter int unsigned LOCK_FILTER = 8
) (
    input  logic clock_in,
    input  logic async_reset_n_in,
    input  logic pll_locked_in,
    output logic lock_qualified
);

    localparam int unsigned FW = $clog2(LOCK_FILTER) + 1;

    logic          lock_meta;
    logic          lock_sync;
    logic [FW-1:0] high_cnt;

    always_ff @(posedge clock_in or negedge async_reset_n_in) begin
        if (!async_reset_n_in) begin
            lock_meta      <= 1'b0;
            lock_sync      <= 1'b0;
            high_cnt       <= '0;
            lock_qualified <= 1'b0;
        end else begin
            lock_meta <= pll_locked_in;
            lock_sync <= lock_meta;
            if (!lock_sync) begin
                // Any low sample restarts qualification from scratch.
                high_cnt       <= '0;
                lock_qualified <= 1'b0;
            end else if (high_cnt != FW'(LOCK_FILTER)) begin
                high_cnt <= high_cnt + FW'(1);
                if (high_cnt == FW'(LOCK_FILTER - 1)) begin
                    lock_qualified <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Purpose : releases STAGES active-low stage resets in order (stage 0 first) after
//           internal reset release and qualified PLL lock; supports soft re-sequencing.
// Latency : stage 0 at lock edge E+2+LOCK_FILTER, stage k STAGE_DELAY cycles later,
//           done one cycle after the last stage; soft request at S -> stages low after S+1.
// Backpr. : none; soft requests outside RELEASE/DONE are dropped.
// Ports   : clock_in, async_reset_n_in (async active-low), pll_locked_in (async),
//           soft_reset_request_in (1-cycle pulse), stage_reset_n_out[STAGES],
//           sequence_done_out, lock_lost_out.
// Config  : define RESET_SEQUENCER_LOCK_LOSS_EN to re-assert all stages when qualified
//           lock is lost after WAIT_LOCK and to drive the sticky lock_lost_out flag;
//           otherwise lock loss after WAIT_LOCK is ignored and lock_lost_out is 0.
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int unsigned STAGES           = 4,
    parameter int unsigned STAGE_DELAY      = 16,
    parameter int unsigned LOCK_FILTER      = 8,
    parameter int unsigned SOFT_HOLD_CYCLES = 32
) (
    input  logic              clock_in,
    input  logic              async_reset_n_in,
    input  logic              pll_locked_in,
    input  logic              soft_reset_request_in,
    output logic [STAGES-1:0] stage_reset_n_out,
    output logic              sequence_done_out,
    output logic              lock_lost_out
);

    localparam int unsigned CNT_W = $clog2(max3(STAGE_DELAY, SOFT_HOLD_CYCLES, LOCK_FILTER)) + 1;

    reset_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STAGES-1:0] stage_q, stage_d;
    logic              done_q, done_d;
    logic              rst_meta, rst_sync;
    logic              soft_req_q;
    logic              lock_qualified;
    logic              lock_drop;
    logic              soft_go;

    // Assert asynchronously, deassert through two flops so HOLD exits cleanly.
    always_ff @(posedge clock_in or negedge async_reset_n_in) begin
        if (!async_reset_n_in) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    lock_filter #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_filter (
        .clock_in         (clock_in),
        .async_reset_n_in (async_reset_n_in),
        .pll_locked_in    (pll_locked_in),
        .lock_qualified   (lock_qualified)
    );

    // The request is registered first; the FSM acts on it one edge after sampling.
    always_ff @(posedge clock_in or negedge async_reset_n_in) begin
        if (!async_reset_n_in) begin
            soft_req_q <= 1'b0;
        end else begin
            soft_req_q <= soft_reset_request_in;
        end
    end

`ifdef RESET_SEQUENCER_LOCK_LOSS_EN
    logic lost_q;

    assign lock_drop = !lock_qualified &&
                       (state_q == RELEASE || state_q == DONE || state_q == SOFT_HOLD);

    // Sticky until a soft request; a simultaneous loss wins over the clear.
    always_ff @(posedge clock_in or negedge async_reset_n_in) begin
        if (!async_reset_n_in) begin
            lost_q <= 1'b0;
        end else if (lock_drop) begin
            lost_q <= 1'b1;
        end else if (soft_req_q) begin
            lost_q <= 1'b0;
        end
    end

    assign lock_lost_out = lost_q;
`else
    assign lock_drop     = 1'b0;
    assign lock_lost_out = 1'b0;
`endif

    assign soft_go = soft_req_q && (state_q == RELEASE || state_q == DONE);

    always_ff @(posedge clock_in or negedge async_reset_n_in) begin
        if (!async_reset_n_in) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        done_d  = done_q;
        // Saturate rather than wrap; every state entry below reloads zero.
        cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

        unique case (state_q)
            HOLD: begin
                stage_d = '0;
                done_d  = 1'b0;
                if (rst_sync) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                stage_d = '0;
                done_d  = 1'b0;
                if (lock_qualified) begin
                    state_d = RELEASE;
                    stage_d = STAGES'(1);
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                done_d = 1'b0;
                if (stage_q[STAGES-1]) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
                    // Thermometer fill keeps release strictly in bit order.
                    stage_d = (stage_q << 1) | STAGES'(1);
                    cnt_d   = '0;
                end
            end
            DONE: begin
                done_d = 1'b1;
            end
            SOFT_HOLD: begin
                stage_d = '0;
                done_d  = 1'b0;
                if (cnt_q == CNT_W'(SOFT_HOLD_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = HOLD;
                stage_d = '0;
                done_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase

        // Lock loss outranks a coincident soft request.
        if (lock_drop) begin
            state_d = WAIT_LOCK;
            stage_d = '0;
            done_d  = 1'b0;
            cnt_d   = '0;
        end else if (soft_go) begin
            state_d = SOFT_HOLD;
            stage_d = '0;
            done_d  = 1'b0;
            cnt_d   = '0;
        end
    end

    assign stage_reset_n_out = stage_q;
    assign sequence_done_out = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Purpose : directed bench for reset_sequencer at default parameters.
// Latency : n/a.
// Backpr. : n/a.
module tb_reset_sequencer;

    logic       clock_in;
    logic       async_reset_n_in;
    logic       pll_locked_in;
    logic       soft_reset_request_in;
    logic [3:0] stage_reset_n_out;
    logic       sequence_done_out;
    logic       lock_lost_out;

    int n_chk;
    int n_pass;
    int n_fail;

    reset_sequencer #(
        .STAGES           (4),
        .STAGE_DELAY      (16),
        .LOCK_FILTER      (8),
        .SOFT_HOLD_CYCLES (32)
    ) dut (
        .clock_in              (clock_in),
        .async_reset_n_in      (async_reset_n_in),
        .pll_locked_in         (pll_locked_in),
        .soft_reset_request_in (soft_reset_request_in),
        .stage_reset_n_out     (stage_reset_n_out),
        .sequence_done_out     (sequence_done_out),
        .lock_lost_out         (lock_lost_out)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    // Compares {lock_lost, done, stages[3:0]} against the expected 6-bit value.
    task automatic check(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {lock_lost_out, sequence_done_out, stage_reset_n_out};
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got lost/done/stages=%b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        n_fail = 0;
        async_reset_n_in      = 1'b0;
        pll_locked_in         = 1'b0;
        soft_reset_request_in = 1'b0;

        // Reset state, before and after clocks arrive.
        #3;
        check("reset_no_clock", 6'b00_0000);
        step(2);
        check("reset_clocked", 6'b00_0000);

        // Power-up: release reset, let FSM reach WAIT_LOCK, then lock before edge E.
        async_reset_n_in = 1'b1;
        step(5);
        check("wait_lock_idle", 6'b00_0000);
        pll_locked_in = 1'b1;
        step(1);                                   // E
        step(9);                                   // E+9
        check("pu_e9_no_stage", 6'b00_0000);
        step(1);                                   // E+10
        check("pu_stage0", 6'b00_0001);
        step(15);                                  // E+25
        check("pu_e25_hold", 6'b00_0001);
        step(1);                                   // E+26
        check("pu_stage1", 6'b00_0011);
        step(16);                                  // E+42
        check("pu_stage2", 6'b00_0111);
        step(16);                                  // E+58
        check("pu_stage3", 6'b00_1111);
        step(1);                                   // E+59
        check("pu_done", 6'b01_1111);

        // Asynchronous reset from DONE, then lock glitch during qualification.
        #2;
        async_reset_n_in = 1'b0;
        pll_locked_in    = 1'b0;
        #1;
        check("async_from_done", 6'b00_0000);
        step(3);
        async_reset_n_in = 1'b1;
        step(5);
        pll_locked_in = 1'b1;
        step(1);                                   // G
        step(6);                                   // G+6: 7 high samples taken
        pll_locked_in = 1'b0;
        step(1);                                   // G+7: the one low sample
        pll_locked_in = 1'b1;
        step(3);                                   // G+10
        check("glitch_g10", 6'b00_0000);
        step(7);                                   // G+17
        check("glitch_g17", 6'b00_0000);
        step(1);                                   // G+18
        check("glitch_stage0", 6'b00_0001);
        step(49);                                  // G+67
        check("glitch_done", 6'b01_1111);

        // Soft reset in DONE.
        soft_reset_request_in = 1'b1;
        step(1);                                   // S
        soft_reset_request_in = 1'b0;
        check("soft_done_s", 6'b01_1111);
        step(1);                                   // S+1
        check("soft_done_s1", 6'b00_0000);
        step(32);                                  // S+33
        check("soft_done_s33", 6'b00_0000);
        step(1);                                   // S+34
        check("soft_done_s34", 6'b00_0001);
        step(16);                                  // S+50 = T1
        check("soft_stage1", 6'b00_0011);

        // Soft reset just after stage 1 releases, plus an ignored pulse in SOFT_HOLD.
        soft_reset_request_in = 1'b1;
        step(1);                                   // T1+1
        soft_reset_request_in = 1'b0;
        check("mid_t1", 6'b00_0011);
        step(1);                                   // T1+2
        check("mid_drop", 6'b00_0000);
        step(8);                                   // T1+10
        soft_reset_request_in = 1'b1;
        step(1);                                   // T1+11
        soft_reset_request_in = 1'b0;
        step(23);                                  // T1+34
        check("mid_t34", 6'b00_0000);
        step(1);                                   // T1+35
        check("mid_restart", 6'b00_0001);
        step(49);                                  // T1+84
        check("mid_done", 6'b01_1111);

        // Lock loss while in DONE.
        pll_locked_in = 1'b0;
        step(1);                                   // F
        step(2);                                   // F+2
        check("loss_f2", 6'b01_1111);
        step(1);                                   // F+3
`ifdef RESET_SEQUENCER_LOCK_LOSS_EN
        check("loss_f3", 6'b10_0000);
        step(3);
        check("loss_f6", 6'b10_0000);
`else
        check("loss_f3", 6'b01_1111);
        step(3);
        check("loss_f6", 6'b01_1111);
`endif
        pll_locked_in = 1'b1;
        step(12);                                  // F'+11
`ifdef RESET_SEQUENCER_LOCK_LOSS_EN
        check("relock", 6'b10_0001);
`else
        check("relock", 6'b01_1111);
`endif
        soft_reset_request_in = 1'b1;
        step(1);                                   // S
        soft_reset_request_in = 1'b0;
        step(1);                                   // S+1
        check("lost_cleared", 6'b00_0000);
        step(33);                                  // S+34
        check("relock_stage0", 6'b00_0001);

        // Asynchronous reset mid-RELEASE, between edges.
        step(5);
        #2;
        async_reset_n_in = 1'b0;
        #1;
        check("async_mid_release", 6'b00_0000);
        step(2);
        check("async_held", 6'b00_0000);
        async_reset_n_in = 1'b1;
        step(3);
        check("after_async", 6'b00_0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
